v_lane_seq: RTL and testbench
=============================

# v_lane_seq

Beat sequencer for the 16-lane vector datapath (four 128-bit lane groups of four 32-bit ALU/MUL lanes each). It accepts one vector operation per start handshake and derives the beat count from the latched `lmul`/`lanes` configuration. Per beat it drives the operand-group select mask; after a fixed unit latency it drives the matching result write-back mask, then pulses `done`. It replaces ad-hoc step counters inside the lane array and sits between the vector decode stage and the lane array.

## Interface
- `UNIT_LAT`, 1, cycles from operand issue to valid ALU/MUL result; legal range 1..4
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request to begin an operation; accepted when `start & ready`
- `lmul`  in  3  register grouping: 0 = 1 group, 1 = 2 groups, 2 = 4 groups; values ≥3 are illegal
- `lanes`  in  2  lane capacity per beat: 0 = 4 lanes (1 group), 1 = 8 (2 groups), 2 = 16 (4 groups); 3 is illegal
- `ready`  out  1  high in IDLE and DONE
- `busy`  out  1  high in ISSUE and DRAIN
- `issue_valid`  out  1  operand beat presented to the lanes this cycle
- `issue_mask`  out  4  one-hot-per-group operand selection for this beat
- `wb_valid`  out  1  result beat valid this cycle
- `wb_mask`  out  4  result groups to capture this cycle
- `done`  out  1  one-cycle pulse marking operation completion
- `cfg_err`  out  1  one-cycle pulse when a start is accepted with an illegal config

## Operation
- Reset value of every output is 0, except `ready`, which resets to 1. State resets to IDLE and the pipeline resets to empty.
- `lmul` and `lanes` are latched on accept. Changes to them during an operation are ignored.
- Derived values:
  - G = 1<<lmul
  - C = 1<<lanes
  - B = max(1, G/C)
  - beat k mask = ((1<<min(G,C))−1) << (k·C)
- Mask examples:
  - lmul=2, lanes=0 → masks 0001, 0010, 0100, 1000
  - lmul=2, lanes=1 → masks 0011, 1100
  - lmul=1, lanes=2 → mask 0011
- FSM:
  - IDLE: on accept go to ISSUE. With an illegal config, instead pulse `cfg_err` next cycle and stay IDLE; no beats are issued.
  - ISSUE: issue one beat per cycle and increment the beat counter (2 bits). After beat B−1, go to DRAIN.
  - DRAIN: count down UNIT_LAT cycles until the last write-back retires, then go to DONE.
  - DONE: pulse `done` for one cycle, `ready`=1. An accept in DONE goes directly to ISSUE (back-to-back operation). Otherwise go to IDLE.
- Write-back path: `wb_valid`/`wb_mask` are `issue_valid`/`issue_mask` delayed by exactly UNIT_LAT cycles.
- `start` while `busy` is ignored and not queued.
- Reset asserted mid-operation: all outputs clear immediately, in-flight write-backs are dropped, and no `done` is produced.

## Timing
- Accept at edge T. Beats issue in cycles T+1 … T+B.
- Write-backs occur in cycles T+1+UNIT_LAT … T+B+UNIT_LAT.
- `done` is asserted in cycle T+B+UNIT_LAT+1.
- Total latency from accept to `done` is B+UNIT_LAT+1 cycles (stall-free).
- Back-to-back: accept in the DONE cycle D. The next operation's first beat issues at D+1.

## Configuration
- `V_LANE_SEQ_STALL_EN`
  - Defined: adds input port `stall` (1 bit). While `stall`=1 in ISSUE, `issue_valid`=0 and the beat counter holds. The write-back pipeline keeps advancing, so in-flight beats still retire. The DRAIN countdown starts only after the last beat actually issues.
  - Undefined: no `stall` port; the sequencer never pauses.

## Structure
- Package `v_lane_pkg` holds:
  - the `lmul_e` and `lanes_e` encodings
  - the FSM state enum (IDLE, ISSUE, DRAIN, DONE)
  - constant `V_NUM_GROUPS = 4`
  - the mask-computation function
- One sub-module, `v_lane_wb_pipe`: a UNIT_LAT-deep shift register of {valid, mask[3:0]} with async active-high reset.

## Test plan
- UNIT_LAT=1, lmul=0, lanes=0, start at T:
  - `issue_mask`=0001 at T+1, `wb_mask`=0001 at T+2
  - `done` at T+3
- lmul=2, lanes=0:
  - masks 0001, 0010, 0100, 1000 in consecutive cycles
  - `done` 6 cycles after accept
  - `start` pulses while `busy` are ignored
- lmul=2, lanes=1 then lmul=1, lanes=2, accepted in the DONE cycle:
  - issue masks 0011, 1100, then 0011 with no idle gap
  - two `done` pulses
- lanes=3 or lmul=3: `cfg_err` pulse one cycle after accept; no `issue_valid`, no `done`, `ready` stays 1.
- `rst` asserted during the third beat of lmul=2, lanes=0: all outputs 0 and `ready`=1 asynchronously; no `wb_valid`/`done` afterwards.
- With `V_LANE_SEQ_STALL_EN`, lmul=2, lanes=1, UNIT_LAT=2, `stall` high for 3 cycles after the first beat:
  - second beat (1100) delayed by 3 cycles
  - beat-1 write-back (0011) still occurs 2 cycles after its issue
  - `done` 3 cycles later than the unstalled case

Source files
------------

// File: rtl/v_lane_pkg.sv
// v_lane_pkg: shared encodings, FSM states and beat-mask helpers for the vector lane sequencer.
package v_lane_pkg;
  localparam int V_NUM_GROUPS = 4;
  typedef enum logic [2:0] {LMUL_1 = 3'd0, LMUL_2 = 3'd1, LMUL_4 = 3'd2} lmul_e;
  typedef enum logic [1:0] {LANES_4 = 2'd0, LANES_8 = 2'd1, LANES_16 = 2'd2} lanes_e;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
  function automatic logic [V_NUM_GROUPS-1:0] beat_mask(input logic [1:0] lm, input logic [1:0] ln, input logic [1:0] k);
    logic [1:0] w;
    logic [7:0] base;
    w = (lm < ln) ? lm : ln;
    base = (8'd1 << (4'd1 << w)) - 8'd1;
    return V_NUM_GROUPS'(base << (4'(k) << ln));
  endfunction
  // Index of the final beat: G/C - 1 when the register group spans several beats.
  function automatic logic [1:0] beat_last(input logic [1:0] lm, input logic [1:0] ln);
    return (lm > ln) ? 2'((3'd1 << (lm - ln)) - 3'd1) : 2'd0;
  endfunction
endpackage

// File: rtl/v_lane_wb_pipe.sv
// v_lane_wb_pipe: DEPTH-stage delay line carrying {valid, mask} from operand issue to write-back.
module v_lane_wb_pipe import v_lane_pkg::*; #(
  parameter int DEPTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  input  logic [V_NUM_GROUPS-1:0] issue_mask,
  output logic                    wb_valid,
  output logic [V_NUM_GROUPS-1:0] wb_mask
);
  logic [V_NUM_GROUPS:0] pipe [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {issue_valid, issue_mask};
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  assign {wb_valid, wb_mask} = pipe[DEPTH-1];
endmodule

// File: rtl/v_lane_seq.sv
// v_lane_seq: beat sequencer issuing per-beat group masks and delayed write-back masks.
// Optional V_LANE_SEQ_STALL_EN adds a stall input that pauses beat issue.
module v_lane_seq import v_lane_pkg::*; #(
  parameter int UNIT_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] lmul,
  input  logic [1:0] lanes,
`ifdef V_LANE_SEQ_STALL_EN
  input  logic       stall,
`endif
  output logic       ready,
  output logic       busy,
  output logic       issue_valid,
  output logic [3:0] issue_mask,
  output logic       wb_valid,
  output logic [3:0] wb_mask,
  output logic       done,
  output logic       cfg_err
);
  localparam logic [1:0] DRAIN_INIT = 2'(UNIT_LAT - 1);
  state_e state, state_n;
  logic [1:0] cnt, cnt_n, lm_q, lm_n, ln_q, ln_n;
  logic err_n, hold, accept, legal, last;
`ifdef V_LANE_SEQ_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif
  assign ready = state == IDLE || state == DONE;
  assign busy = state == ISSUE || state == DRAIN;
  assign done = state == DONE;
  assign accept = start && ready;
  assign legal = lmul <= LMUL_4 && lanes <= LANES_16;
  assign last = cnt == beat_last(lm_q, ln_q);
  assign issue_valid = state == ISSUE && !hold;
  assign issue_mask = issue_valid ? beat_mask(lm_q, ln_q, cnt) : 4'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      lm_q <= '0;
      ln_q <= '0;
      cfg_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      lm_q <= lm_n;
      ln_q <= ln_n;
      cfg_err <= err_n;
    end
  // cnt is the beat index while issuing and the remaining latency while draining.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    lm_n = lm_q;
    ln_n = ln_q;
    err_n = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_n = accept && legal ? ISSUE : IDLE;
        err_n = accept && !legal;
        if (accept && legal) begin
          cnt_n = '0;
          lm_n = lmul[1:0];
          ln_n = lanes;
        end
      end
      ISSUE: if (!hold) begin
        state_n = last ? DRAIN : ISSUE;
        cnt_n = last ? DRAIN_INIT : cnt + 2'd1;
      end
      DRAIN: begin
        state_n = cnt == 2'd0 ? DONE : DRAIN;
        cnt_n = cnt - 2'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  v_lane_wb_pipe #(.DEPTH(UNIT_LAT)) u_wb_pipe (
    .clk(clk),
    .rst(rst),
    .issue_valid(issue_valid),
    .issue_mask(issue_mask),
    .wb_valid(wb_valid),
    .wb_mask(wb_mask)
  );
endmodule

// File: tb/tb_v_lane_seq.sv
// tb_v_lane_seq: directed stimulus with a cycle-level reference model and literal checks.
module tb_v_lane_seq;
`ifdef V_LANE_SEQ_STALL_EN
  localparam int UL = 2;
`else
  localparam int UL = 1;
`endif
  logic clk = 0, rst = 0, start = 0, stall = 0;
  logic [2:0] lmul = 0;
  logic [1:0] lanes = 0;
  logic ready, busy, issue_valid, wb_valid, done, cfg_err;
  logic [3:0] issue_mask, wb_mask;
  int n_chk = 0, n_fail = 0, cyc = 0, a0, a1;
  logic [3:0] beats[$];
  logic [3:0] wb_sched[int];
  int done_at = -1, err_at = -1, drain_end = -1;
  int iss_c[$], iss_m[$], wb_c[$], wb_m[$], done_c[$], err_c[$];
  int m2[4] = '{1, 2, 4, 8};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  v_lane_seq #(.UNIT_LAT(UL)) dut (
    .clk(clk), .rst(rst), .start(start), .lmul(lmul), .lanes(lanes),
`ifdef V_LANE_SEQ_STALL_EN
    .stall(stall),
`endif
    .ready(ready), .busy(busy), .issue_valid(issue_valid), .issue_mask(issue_mask),
    .wb_valid(wb_valid), .wb_mask(wb_mask), .done(done), .cfg_err(cfg_err)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qi(input int q[$], input int i);
    return i < q.size() ? q[i] : -1;
  endfunction

  // Reference model: a queue of pending beat masks plus a cycle-indexed write-back schedule.
  always @(negedge clk) begin
    logic e_iv, e_wv, e_busy;
    logic [3:0] e_im, e_wm;
    int g, c, b, w;
    if (rst) begin
      chk("reset_outputs", 16'({ready, busy, issue_valid, issue_mask, wb_valid, wb_mask, done, cfg_err}), 16'h2000);
      beats.delete();
      wb_sched.delete();
      done_at = -1;
      err_at = -1;
      drain_end = -1;
    end else begin
      e_busy = beats.size() > 0 || cyc <= drain_end;
      e_iv = beats.size() > 0 && !stall;
      e_im = 4'd0;
      if (e_iv) e_im = beats[0];
      e_wv = wb_sched.exists(cyc);
      e_wm = 4'd0;
      if (e_wv) e_wm = wb_sched[cyc];
      chk("ready", 16'(ready), 16'(!e_busy));
      chk("busy", 16'(busy), 16'(e_busy));
      chk("issue_valid", 16'(issue_valid), 16'(e_iv));
      chk("issue_mask", 16'(issue_mask), 16'(e_im));
      chk("wb_valid", 16'(wb_valid), 16'(e_wv));
      chk("wb_mask", 16'(wb_mask), 16'(e_wm));
      chk("done", 16'(done), 16'(cyc == done_at));
      chk("cfg_err", 16'(cfg_err), 16'(cyc == err_at));
      if (issue_valid) begin iss_c.push_back(cyc); iss_m.push_back(int'(issue_mask)); end
      if (wb_valid) begin wb_c.push_back(cyc); wb_m.push_back(int'(wb_mask)); end
      if (done) done_c.push_back(cyc);
      if (cfg_err) err_c.push_back(cyc);
      if (e_iv) begin
        wb_sched[cyc + UL] = beats.pop_front();
        if (beats.size() == 0) begin
          drain_end = cyc + UL;
          done_at = cyc + UL + 1;
        end
      end
      if (start && !e_busy) begin
        if (lmul < 3'd3 && lanes < 2'd3) begin
          g = 1 << lmul;
          c = 1 << lanes;
          b = g > c ? g / c : 1;
          w = g < c ? g : c;
          for (int k = 0; k < b; k++) beats.push_back(4'(((1 << w) - 1) << (k * c)));
        end else err_at = cyc + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [2:0] lm, input logic [1:0] ln);
    start = 1;
    lmul = lm;
    lanes = ln;
    tick();
    start = 0;
  endtask

  task automatic clear_logs();
    iss_c.delete(); iss_m.delete(); wb_c.delete(); wb_m.delete(); done_c.delete(); err_c.delete();
  endtask

  initial begin
    #1 rst = 1;
    tick();
    chk("reset_ready", 16'(ready), 16'd1);
    chk("reset_done", 16'(done), 16'd0);
    tick();
    rst = 0;
    tick();
    // Single beat, one group.
    clear_logs();
    a0 = cyc;
    go(3'd0, 2'd0);
    repeat (5) tick();
    chk("t1_issue_count", 16'(iss_c.size()), 16'd1);
    chk("t1_issue_cycle", 16'(qi(iss_c, 0)), 16'(a0 + 1));
    chk("t1_issue_mask", 16'(qi(iss_m, 0)), 16'b0001);
    chk("t1_wb_cycle", 16'(qi(wb_c, 0)), 16'(a0 + 1 + UL));
    chk("t1_wb_mask", 16'(qi(wb_m, 0)), 16'b0001);
    chk("t1_done_cycle", 16'(qi(done_c, 0)), 16'(a0 + 2 + UL));
    chk("t1_done_count", 16'(done_c.size()), 16'd1);
    // Four beats; starts and config changes while busy are ignored.
    clear_logs();
    a0 = cyc;
    go(3'd2, 2'd0);
    tick();
    start = 1;
    lmul = 3'd0;
    tick();
    tick();
    start = 0;
    repeat (8) tick();
    chk("t2_issue_count", 16'(iss_c.size()), 16'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_issue_mask", 16'(qi(iss_m, i)), 16'(m2[i]));
      chk("t2_issue_cycle", 16'(qi(iss_c, i)), 16'(a0 + 1 + i));
    end
    chk("t2_done_cycle", 16'(qi(done_c, 0)), 16'(a0 + 5 + UL));
    chk("t2_done_count", 16'(done_c.size()), 16'd1);
    // Back-to-back accept in the DONE cycle.
    clear_logs();
    a0 = cyc;
    go(3'd2, 2'd1);
    for (int i = 0; i < 20 && !done; i++) tick();
    chk("t3_done_seen", 16'(done), 16'd1);
    a1 = cyc;
    go(3'd1, 2'd2);
    repeat (8) tick();
    chk("t3_first_done", 16'(a1), 16'(a0 + 3 + UL));
    chk("t3_issue_count", 16'(iss_c.size()), 16'd3);
    chk("t3_mask0", 16'(qi(iss_m, 0)), 16'b0011);
    chk("t3_mask1", 16'(qi(iss_m, 1)), 16'b1100);
    chk("t3_mask2", 16'(qi(iss_m, 2)), 16'b0011);
    chk("t3_no_gap", 16'(qi(iss_c, 2)), 16'(qi(done_c, 0) + 1));
    chk("t3_done_count", 16'(done_c.size()), 16'd2);
    chk("t3_second_done", 16'(qi(done_c, 1)), 16'(a1 + 2 + UL));
    // Illegal configurations.
    clear_logs();
    a0 = cyc;
    go(3'd0, 2'd3);
    tick();
    a1 = cyc;
    go(3'd3, 2'd0);
    repeat (4) tick();
    chk("t4_err_count", 16'(err_c.size()), 16'd2);
    chk("t4_err0_cycle", 16'(qi(err_c, 0)), 16'(a0 + 1));
    chk("t4_err1_cycle", 16'(qi(err_c, 1)), 16'(a1 + 1));
    chk("t4_no_issue", 16'(iss_c.size()), 16'd0);
    chk("t4_no_done", 16'(done_c.size()), 16'd0);
    chk("t4_ready", 16'(ready), 16'd1);
    // Asynchronous reset during the third beat.
    clear_logs();
    go(3'd2, 2'd0);
    tick();
    tick();
    chk("t5_third_beat", 16'(issue_mask), 16'b0100);
    #2 rst = 1;
    #1;
    chk("t5_rst_issue", 16'(issue_valid), 16'd0);
    chk("t5_rst_mask", 16'(issue_mask), 16'd0);
    chk("t5_rst_ready", 16'(ready), 16'd1);
    chk("t5_rst_busy", 16'(busy), 16'd0);
    chk("t5_rst_wb", 16'(wb_valid), 16'd0);
    tick();
    tick();
    rst = 0;
    clear_logs();
    repeat (8) tick();
    chk("t5_no_wb", 16'(wb_c.size()), 16'd0);
    chk("t5_no_done", 16'(done_c.size()), 16'd0);
`ifdef V_LANE_SEQ_STALL_EN
    // Stall for three cycles after the first beat.
    clear_logs();
    a0 = cyc;
    go(3'd2, 2'd1);
    tick();
    stall = 1;
    repeat (3) tick();
    stall = 0;
    repeat (10) tick();
    chk("t6_beat0_cycle", 16'(qi(iss_c, 0)), 16'(a0 + 1));
    chk("t6_beat1_cycle", 16'(qi(iss_c, 1)), 16'(a0 + 5));
    chk("t6_beat1_mask", 16'(qi(iss_m, 1)), 16'b1100);
    chk("t6_wb0_cycle", 16'(qi(wb_c, 0)), 16'(a0 + 1 + UL));
    chk("t6_wb0_mask", 16'(qi(wb_m, 0)), 16'b0011);
    chk("t6_done_cycle", 16'(qi(done_c, 0)), 16'(a0 + 6 + UL));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
